sample_framer: RTL

- Upstream neighbour of the window stage in the pitch-detect pipeline.
- Turns the continuous audio sample stream into overlapping analysis frames of NSamples samples, advancing HOP samples per frame.
- Each frame is replayed oldest-first on a valid/ready stream with a last-sample marker, feeding the window/FFT chain.
- Holds one circular sample buffer and alternates between filling it and emitting it.

---
 rtl/sample_framer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sample_framer.sv
// Circular-buffer framer: collects NSamples-sample frames advancing HOP samples per frame and replays each oldest-first.
// Optional frame_count/overrun statistics ports are compiled in when SAMPLE_FRAMER_STATS_EN is defined.
module sample_framer #(
  parameter int W        = 16,
  parameter int NSamples = 1024,
  parameter int HOP      = 512
) (
  input  logic         clk,
  input  logic         reset,
  // Both streams: a transfer happens on a rising clk edge where valid && ready;
  // a producer holds valid and data stable until that edge, and ready may not depend on valid.
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] x_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data,
  output logic         y_last
`ifdef SAMPLE_FRAMER_STATS_EN
  ,
  output logic [15:0]  frame_count,
  output logic         overrun
`endif
);

  localparam int AW = $clog2(NSamples);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(NSamples);
  localparam logic [CW-1:0] HOP_CNT    = CW'(HOP);
  localparam logic [AW-1:0] PENULT_POS = AW'(NSamples - 2);

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] rd_cnt;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] fill_inc;
  logic [CW-1:0] fill_target;
  logic          x_fire;
  logic          y_fire;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  mem [NSamples];

  assign x_fire      = x_valid && x_ready;
  assign y_fire      = y_valid && y_ready;
  assign fill_inc    = fill_cnt + 1'b1;
  assign fill_target = (state == ST_PRIME) ? FULL_CNT : HOP_CNT;

  // The read port only advances on LOAD or an accepted non-final sample, so y_data holds under stall.
  assign rd_en   = (state == ST_LOAD) || (y_fire && !y_last);
  assign rd_addr = (state == ST_LOAD) ? wp : rp;

  always_comb begin
    state_next = state;
    case (state)
      ST_PRIME, ST_FILL: if (x_fire && (fill_inc == fill_target)) state_next = ST_LOAD;
      ST_LOAD:           state_next = ST_EMIT;
      ST_EMIT:           if (y_fire && y_last) state_next = ST_FILL;
      default:           state_next = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PRIME;
      x_ready  <= 1'b0;
      y_valid  <= 1'b0;
      y_last   <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      rd_cnt   <= '0;
      fill_cnt <= '0;
    end else begin
      state   <= state_next;
      x_ready <= (state_next == ST_PRIME) || (state_next == ST_FILL);
      if (x_fire) begin
        wp       <= wp + 1'b1;
        fill_cnt <= (fill_inc == fill_target) ? '0 : fill_inc;
      end
      if (state == ST_LOAD) begin
        rp      <= wp + 1'b1;
        rd_cnt  <= '0;
        y_valid <= 1'b1;
        y_last  <= 1'b0;
      end else if (y_fire) begin
        if (y_last) begin
          y_valid <= 1'b0;
          y_last  <= 1'b0;
        end else begin
          rp     <= rp + 1'b1;
          rd_cnt <= rd_cnt + 1'b1;
          y_last <= (rd_cnt == PENULT_POS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (x_fire && !reset) mem[wp] <= x_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      y_data <= '0;
    else if (rd_en) y_data <= mem[rd_addr];
  end

`ifdef SAMPLE_FRAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (y_fire && y_last) frame_count <= frame_count + 16'd1;
      if (x_valid && !x_ready) overrun <= 1'b1;
    end
  end
`endif

endmodule
